multi_edge_counter: RTL and testbench

Parametrised multi-channel edge counter. Each channel synchronises an asynchronous input, detects rising, falling or both edges according to a per-channel mode, and counts them in a wrapping or saturating counter with a sticky overflow flag. A valid/ready snapshot port captures all counters atomically for a downstream register/status block. It sits between raw signal pins and the status bus.

---
 rtl/edge_cnt_pkg.sv | 16 +
 rtl/edge_cnt_ch.sv | 83 ++++++++
 rtl/multi_edge_counter.sv | 101 ++++++++++
 tb/tb_multi_edge_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_cnt_pkg.sv
// Shared types for the multi-channel edge counter.
package edge_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_t;

endpackage

// File: rtl/edge_cnt_ch.sv
// One channel: input synchroniser, edge detector, counter with sticky overflow.
module edge_cnt_ch
    import edge_cnt_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig,
    input  mode_t            mode,
    input  logic             sat_en,
    input  logic             clr,
    input  logic             armed,
    input  logic             snap_clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sig_s;
    logic                   sig_d;
    logic                   rise;
    logic                   fall;
    logic                   hit;
    logic [CNT_W-1:0]       base;
    logic                   ovf_base;
    logic [CNT_W-1:0]       cnt_nx;
    logic                   ovf_nx;

    assign sig_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            sig_d <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            sync[0] <= sig;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync[k] <= sync[k-1];
            end
            sig_d <= sig_s;
            count <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        rise = sig_s & ~sig_d;
        fall = ~sig_s & sig_d;
        hit  = 1'b0;
        unique case (mode)
            MODE_OFF:  hit = 1'b0;
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
        endcase
        hit = hit & armed;
    end

    // Snapshot clear rebases to zero but still keeps this cycle's edge.
    always_comb begin
        base     = snap_clr ? '0 : count;
        ovf_base = snap_clr ? 1'b0 : ovf;
        cnt_nx   = base;
        ovf_nx   = ovf_base;
        if (hit) begin
            if (&base) begin
                cnt_nx = sat_en ? base : '0;
                ovf_nx = 1'b1;
            end else begin
                cnt_nx = base + CNT_W'(1);
            end
        end
        if (clr) begin
            cnt_nx = '0;
            ovf_nx = 1'b0;
        end
    end

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel edge counter with arm delay and valid/ready snapshot port.
module multi_edge_counter
    import edge_cnt_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CLR_ON_SNAP = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       sig_in,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic                    sat_en,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       ovf,
    input  logic                    snap_req,
    output logic                    snap_valid,
    input  logic                    snap_ready,
    output logic [NUM_CH*CNT_W-1:0] snap_data,
    output logic                    snap_drop
);

    localparam int ARM_N = SYNC_STAGES + 1;
    localparam int AW    = $clog2(ARM_N + 1);

    logic [AW-1:0] arm_cnt;
    logic          armed;
    snap_state_t   state;
    snap_state_t   state_nx;
    logic          capture;
    logic          drop_nx;
    logic          snap_clr;

    assign armed      = (arm_cnt == AW'(ARM_N));
    assign snap_valid = (state == SNAP_HOLD);
    assign snap_clr   = (CLR_ON_SNAP != 0) && capture;

    // Edges stay masked until the synchroniser and previous-level flop hold real data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + AW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_cnt_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .sig      (sig_in[i]),
            .mode     (mode_t'(mode[2*i +: 2])),
            .sat_en   (sat_en),
            .clr      (clr[i]),
            .armed    (armed),
            .snap_clr (snap_clr),
            .count    (count[i*CNT_W +: CNT_W]),
            .ovf      (ovf[i])
        );
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        drop_nx  = 1'b0;
        unique case (state)
            SNAP_IDLE: begin
                if (snap_req) begin
                    state_nx = SNAP_HOLD;
                    capture  = 1'b1;
                end
            end
            SNAP_HOLD: begin
                drop_nx = snap_req;
                if (snap_ready) begin
                    state_nx = SNAP_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SNAP_IDLE;
            snap_data <= '0;
            snap_drop <= 1'b0;
        end else begin
            state     <= state_nx;
            snap_drop <= drop_nx;
            if (capture) begin
                snap_data <= count;
            end
        end
    end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Self-checking bench: vector table, scoreboard queues and snapshot corner cases.
module tb_multi_edge_counter;

    localparam int NC = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [NC-1:0] sig_in;
    logic [2*NC-1:0] mode;
    logic          sat_en;
    logic [NC-1:0] clr;
    logic [NC*CW-1:0] count;
    logic [NC-1:0] ovf;
    logic          snap_req;
    logic          snap_valid;
    logic          snap_ready;
    logic [NC*CW-1:0] snap_data;
    logic          snap_drop;

    logic          reset2;
    logic [NC-1:0] sig2;
    logic [2*NC-1:0] mode2;
    logic          sat2;
    logic [NC-1:0] clr2;
    logic [NC*CW-1:0] count2;
    logic [NC-1:0] ovf2;
    logic          req2;
    logic          valid2;
    logic          ready2;
    logic [NC*CW-1:0] data2;
    logic          drop2;

    multi_edge_counter #(
        .NUM_CH(NC), .CNT_W(CW), .SYNC_STAGES(2), .CLR_ON_SNAP(0)
    ) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .mode(mode),
        .sat_en(sat_en), .clr(clr), .count(count), .ovf(ovf),
        .snap_req(snap_req), .snap_valid(snap_valid),
        .snap_ready(snap_ready), .snap_data(snap_data),
        .snap_drop(snap_drop)
    );

    multi_edge_counter #(
        .NUM_CH(NC), .CNT_W(CW), .SYNC_STAGES(2), .CLR_ON_SNAP(1)
    ) dut2 (
        .clk(clk), .reset(reset2), .sig_in(sig2), .mode(mode2),
        .sat_en(sat2), .clr(clr2), .count(count2), .ovf(ovf2),
        .snap_req(req2), .snap_valid(valid2),
        .snap_ready(ready2), .snap_data(data2),
        .snap_drop(drop2)
    );

    typedef struct {
        int         ch;
        logic [1:0] md;
        logic       sat;
        int         pulses;
        logic [3:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    vec_t        vecs[7];
    vec_t        sb[$];
    logic [15:0] snap_sb[$];

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_mask(input logic [NC-1:0] m);
        sig_in = sig_in | m;
        tick(2);
        sig_in = sig_in & ~m;
        tick(2);
    endtask

    task automatic wait_snap(output bit seen);
        int w = 0;
        while (!snap_valid && w < 5) begin
            tick();
            w++;
        end
        seen = snap_valid;
    endtask

    initial begin
        vec_t        e;
        logic [15:0] es;
        logic [NC-1:0] m;
        bit          seen;

        vecs[0] = '{1, 2'b11, 1'b0,  5, 4'd10, 1'b0};
        vecs[1] = '{2, 2'b10, 1'b0,  5, 4'd5,  1'b0};
        vecs[2] = '{3, 2'b00, 1'b0,  5, 4'd0,  1'b0};
        vecs[3] = '{0, 2'b01, 1'b0, 17, 4'd1,  1'b1};
        vecs[4] = '{1, 2'b11, 1'b0,  3, 4'd6,  1'b0};
        vecs[5] = '{2, 2'b01, 1'b1, 20, 4'd15, 1'b1};
        vecs[6] = '{0, 2'b01, 1'b1, 17, 4'd15, 1'b1};

        reset = 1'b1; reset2 = 1'b1;
        sig_in = 4'b0001; mode = 8'b0000_0001; sat_en = 1'b0;
        clr = '0; snap_req = 1'b0; snap_ready = 1'b0;
        sig2 = '0; mode2 = 8'b0000_0001; sat2 = 1'b0;
        clr2 = '0; req2 = 1'b0; ready2 = 1'b0;
        tick(3);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid", snap_valid, 0);
        check("rst_data", snap_data, 0);
        check("rst_drop", snap_drop, 0);

        reset = 1'b0; reset2 = 1'b0;
        tick(6);
        check("arm_baseline", count[3:0], 0);
        sig_in[0] = 1'b0;
        tick(4);
        check("rise_ignores_fall", count[3:0], 0);

        sig_in[0] = 1'b1;
        tick();
        tick();
        check("lat_n1", count[3:0], 0);
        tick();
        check("lat_n2", count[3:0], 1);
        sig_in[0] = 1'b0;
        tick(4);

        foreach (vecs[i]) begin
            mode[vecs[i].ch*2 +: 2] = vecs[i].md;
            sat_en = vecs[i].sat;
            tick(3);
            clr[vecs[i].ch] = 1'b1;
            tick();
            clr = '0;
            sb.push_back(vecs[i]);
            repeat (vecs[i].pulses) pulse_mask(NC'(1) << vecs[i].ch);
            tick(3);
            e = sb.pop_front();
            check($sformatf("vec%0d_cnt", i), count[e.ch*CW +: CW], e.exp_cnt);
            check($sformatf("vec%0d_ovf", i), ovf[e.ch], e.exp_ovf);
        end

        clr[0] = 1'b1;
        tick();
        clr = '0;
        check("clr0_cnt", count[3:0], 0);
        check("clr0_ovf", ovf[0], 0);

        mode[3:2] = 2'b01;
        sat_en = 1'b0;
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        sig_in[1] = 1'b1;
        tick();
        tick();
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        check("clr_edge_cnt", count[7:4], 0);
        tick(3);
        check("clr_edge_after", count[7:4], 0);
        check("clr_edge_ovf", ovf[1], 0);
        sig_in[1] = 1'b0;
        tick(3);

        mode = 8'b0101_0101;
        sat_en = 1'b0;
        tick(3);
        clr = '1;
        tick();
        clr = '0;
        for (int k = 0; k < 9; k++) begin
            m = {k < 9, k < 7, k < 5, k < 3};
            pulse_mask(m);
        end
        tick(3);
        check("snap_pre_counts", count, 16'h9753);

        snap_sb.push_back(16'h9753);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        wait_snap(seen);
        check("snap_valid_up", seen, 1);
        es = snap_sb.pop_front();
        check("snap_data", snap_data, es);
        for (int j = 0; j < 4; j++) begin
            if (j == 1) snap_req = 1'b1;
            tick();
            snap_req = 1'b0;
            check($sformatf("snap_stable%0d", j), snap_data, es);
            check($sformatf("snap_hold%0d", j), snap_valid, 1);
            if (j == 1) check("snap_drop_on", snap_drop, 1);
            if (j == 2) check("snap_drop_off", snap_drop, 0);
        end
        snap_ready = 1'b1;
        snap_req = 1'b1;
        tick();
        snap_ready = 1'b0;
        snap_req = 1'b0;
        check("snap_release", snap_valid, 0);
        check("drop_on_handshake", snap_drop, 1);

        snap_sb.push_back(16'h9753);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        check("b2b_capture", snap_valid, 1);
        es = snap_sb.pop_front();
        check("b2b_data", snap_data, es);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("b2b_release", snap_valid, 0);

        repeat (6) begin
            sig2[0] = 1'b1;
            tick(2);
            sig2[0] = 1'b0;
            tick(2);
        end
        tick(3);
        check("cos_pre", count2[3:0], 6);
        sig2[0] = 1'b1;
        tick();
        tick();
        req2 = 1'b1;
        tick();
        req2 = 1'b0;
        check("cos_data", data2[3:0], 6);
        check("cos_count", count2[3:0], 1);
        check("cos_valid", valid2, 1);
        #2;
        reset2 = 1'b1;
        #1;
        check("cos_rst_valid", valid2, 0);
        check("cos_rst_count", count2, 0);
        tick();
        reset2 = 1'b0;
        sig2 = '0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
